// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, derived totals and sync windows shared by the VGA timing blocks.
package vga_pkg;

    typedef logic [9:0] coord_t;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int GAME_DIV = 12;

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Sync windows are half-open: [START, END).
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

endpackage

// File: rtl/vga_timing_gen_wrap_counter.sv
// Enable-gated counter 0..MAX with synchronous clear; wrap is high combinationally on the enable that returns it to 0.
module wrap_counter
    import vga_pkg::*;
#(
    parameter int MAX = 799
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   clr,
    output coord_t count,
    output logic   wrap
);

    localparam coord_t MAX_C = coord_t'(MAX);

    assign wrap = en && (count == MAX_C);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: registered decode of (h_cnt, v_cnt) on each pixel enable, plus per-frame strobe.
// Optional game_tick divider is built only when VGA_GAME_TICK_EN is defined; otherwise game_tick is tied low.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE_P = vga_pkg::H_ACTIVE,
    parameter int H_FP_P     = vga_pkg::H_FP,
    parameter int H_SYNC_P   = vga_pkg::H_SYNC,
    parameter int H_BP_P     = vga_pkg::H_BP,
    parameter int V_ACTIVE_P = vga_pkg::V_ACTIVE,
    parameter int V_FP_P     = vga_pkg::V_FP,
    parameter int V_SYNC_P   = vga_pkg::V_SYNC,
    parameter int V_BP_P     = vga_pkg::V_BP,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0,
    parameter int GAME_DIV_P = vga_pkg::GAME_DIV
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_tick,
    output logic       game_tick
);

    localparam int H_TOT = H_ACTIVE_P + H_FP_P + H_SYNC_P + H_BP_P;
    localparam int V_TOT = V_ACTIVE_P + V_FP_P + V_SYNC_P + V_BP_P;

    localparam coord_t HA  = coord_t'(H_ACTIVE_P);
    localparam coord_t VA  = coord_t'(V_ACTIVE_P);
    localparam coord_t HSS = coord_t'(H_ACTIVE_P + H_FP_P);
    localparam coord_t HSE = coord_t'(H_ACTIVE_P + H_FP_P + H_SYNC_P);
    localparam coord_t VSS = coord_t'(V_ACTIVE_P + V_FP_P);
    localparam coord_t VSE = coord_t'(V_ACTIVE_P + V_FP_P + V_SYNC_P);

    coord_t h_cnt;
    coord_t v_cnt;
    logic   h_wrap;
    logic   v_wrap_unused;
    logic   frame_start;

    wrap_counter #(.MAX(H_TOT - 1)) u_h_cnt (
        .clk   (clk_100MHz),
        .rst   (reset),
        .en    (pix_en),
        .clr   (1'b0),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    wrap_counter #(.MAX(V_TOT - 1)) u_v_cnt (
        .clk   (clk_100MHz),
        .rst   (reset),
        .en    (h_wrap),
        .clr   (1'b0),
        .count (v_cnt),
        .wrap  (v_wrap_unused)
    );

    // The enable that presents (0, V_ACTIVE) at the outputs marks the start of vertical blank.
    assign frame_start = pix_en && (h_cnt == '0) && (v_cnt == VA);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            video_on   <= 1'b0;
            hsync      <= ~HS_POL;
            vsync      <= ~VS_POL;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_start;
            if (pix_en) begin
                x        <= h_cnt;
                y        <= v_cnt;
                video_on <= (h_cnt < HA) && (v_cnt < VA);
                hsync    <= ((h_cnt >= HSS) && (h_cnt < HSE)) ? HS_POL : ~HS_POL;
                vsync    <= ((v_cnt >= VSS) && (v_cnt < VSE)) ? VS_POL : ~VS_POL;
            end
        end
    end

`ifdef VGA_GAME_TICK_EN
    coord_t frame_cnt_unused;
    logic   frame_wrap;

    wrap_counter #(.MAX(GAME_DIV_P - 1)) u_frame_cnt (
        .clk   (clk_100MHz),
        .rst   (reset),
        .en    (frame_start),
        .clr   (1'b0),
        .count (frame_cnt_unused),
        .wrap  (frame_wrap)
    );

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            game_tick <= 1'b0;
        end else begin
            game_tick <= frame_wrap;
        end
    end
`else
    assign game_tick = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench for vga_timing_gen on a reduced raster, checked every clock against a position-from-enable-count model.
module tb_vga_timing_gen;

    localparam int HA = 16, HFP = 2, HSY = 3, HBP = 3;
    localparam int VA = 6,  VFP = 2, VSY = 2, VBP = 2;
    localparam int GD = 3;
    localparam int HT = HA + HFP + HSY + HBP;
    localparam int VT = VA + VFP + VSY + VBP;
    localparam int FRAME = HT * VT;
`ifdef VGA_GAME_TICK_EN
    localparam bit GT_ON = 1'b1;
`else
    localparam bit GT_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pix_en = 1'b0;
    logic       hsync, vsync, video_on, frame_tick, game_tick;
    logic [9:0] x, y;

    vga_timing_gen #(
        .H_ACTIVE_P(HA), .H_FP_P(HFP), .H_SYNC_P(HSY), .H_BP_P(HBP),
        .V_ACTIVE_P(VA), .V_FP_P(VFP), .V_SYNC_P(VSY), .V_BP_P(VBP),
        .HS_POL(1'b0), .VS_POL(1'b0), .GAME_DIV_P(GD)
    ) dut (
        .clk_100MHz (clk),
        .reset      (reset),
        .pix_en     (pix_en),
        .hsync      (hsync),
        .vsync      (vsync),
        .video_on   (video_on),
        .x          (x),
        .y          (y),
        .frame_tick (frame_tick),
        .game_tick  (game_tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: enables since reset, frame strobes since reset, expected outputs.
    int unsigned k = 0;
    int unsigned frames = 0;
    int unsigned cyc_no = 0;
    int unsigned ft_cnt = 0;
    int unsigned gt_cnt = 0;
    int unsigned last_ft = 0;
    int unsigned ft_gap = 0;
    int   ex = 0, ey = 0;
    logic evo = 0, ehs = 1, evs = 1, eft = 0, egt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        k = 0; frames = 0;
        ex = 0; ey = 0; evo = 0; ehs = 1; evs = 1; eft = 0; egt = 0;
    endtask

    task automatic check_outputs();
        check("x", 32'(x), 32'(ex));
        check("y", 32'(y), 32'(ey));
        check("video_on", 32'(video_on), 32'(evo));
        check("hsync", 32'(hsync), 32'(ehs));
        check("vsync", 32'(vsync), 32'(evs));
        check("frame_tick", 32'(frame_tick), 32'(eft));
        check("game_tick", 32'(game_tick), 32'(egt));
    endtask

    // One clock with the given enable; outputs are compared 1 time unit after the edge.
    task automatic cyc(input logic en);
        int p;
        pix_en = en;
        @(posedge clk);
        #1;
        cyc_no++;
        eft = 0;
        egt = 0;
        if (en) begin
            p  = int'(k % FRAME);
            k++;
            ex = p % HT;
            ey = p / HT;
            evo = (ex < HA) && (ey < VA);
            ehs = !((ex >= HA + HFP) && (ex < HA + HFP + HSY));
            evs = !((ey >= VA + VFP) && (ey < VA + VFP + VSY));
            if (ex == 0 && ey == VA) begin
                eft = 1;
                frames++;
                egt = GT_ON && (frames % GD == 0);
            end
        end
        check_outputs();
        if (frame_tick) begin
            ft_cnt++;
            ft_gap = cyc_no - last_ft;
            last_ft = cyc_no;
        end
        if (game_tick) gt_cnt++;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs();
        #2 reset = 1'b0;

        // Continuous enables across three frames.
        ft_cnt = 0; gt_cnt = 0;
        for (int i = 0; i < 3 * FRAME + 20; i++) cyc(1'b1);
        check("ft_count_cont", ft_cnt, 3);
        check("gt_count_cont", gt_cnt, GT_ON ? 1 : 0);
        check("x_end_cont", 32'(x), 32'(19));
        check("y_end_cont", 32'(y), 32'(0));

        // One enable in four; consecutive strobes must be 4*FRAME clocks apart.
        ft_cnt = 0;
        for (int i = 0; i < 4 * (2 * FRAME + 10); i++) cyc((i % 4) == 0);
        check("ft_count_q", ft_cnt, 2);
        check("ft_gap_q", ft_gap, 4 * FRAME);

        // Random duty cycle.
        for (int i = 0; i < 2500; i++) cyc(1'(($urandom % 3) != 0));

        // Asynchronous reset between edges, then restart from (0,0).
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < int'($urandom_range(50, 400)); i++) cyc(1'($urandom));
            @(negedge clk);
            #1 reset = 1'b1;
            #1;
            model_reset();
            check_outputs();
            @(posedge clk);
            #2 reset = 1'b0;
            ft_cnt = 0;
            for (int i = 0; i < FRAME + 30; i++) cyc(1'b1);
            check("ft_after_reset", ft_cnt, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Consumes the 25 MHz pixel-enable tick from the clock generator and produces 640x480@60 VGA timing: hsync, vsync, video_on and pixel coordinates.
- Also produces a one-cycle frame strobe that replaces the free-running 60 Hz toggle as the game-update event.
- Sits between the clock generator and the renderer/game logic. All logic runs on the 100 MHz clock and advances only on pixel-enable cycles.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hsync
- VS_POL, 0, active level of vsync
- GAME_DIV, 12, frames per game_tick (used only with the optional feature)

Ports:
- clk_100MHz  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-enable tick; any duty cycle allowed
- hsync  out  1  horizontal sync, active level HS_POL
- vsync  out  1  vertical sync, active level VS_POL
- video_on  out  1  high while the output pixel is in the active area
- x  out  10  horizontal coordinate of the output pixel
- y  out  10  vertical coordinate of the output pixel
- frame_tick  out  1  one-clock pulse at the start of vertical blank
- game_tick  out  1  one-clock pulse every GAME_DIV frames

Behaviour:
- One clock domain (clk_100MHz). reset is asynchronous and active-high.
- Reset values:
  - internal h_cnt = 0, v_cnt = 0, frame counter = 0
  - x = 0, y = 0, video_on = 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - frame_tick = 0, game_tick = 0
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- On a clock edge with pix_en=1:
  - Register the decode of the current (h_cnt, v_cnt) into the outputs.
  - Then advance: h_cnt+1, wrapping at H_TOTAL-1 to 0. On that wrap, v_cnt+1, wrapping at V_TOTAL-1 to 0.
  - Outputs therefore lag the counters by one enable.
- Decode rules:
  - x = h_cnt, y = v_cnt (zero-extended to 10 bits)
  - video_on = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)
  - hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751
  - vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491
- On a clock edge with pix_en=0: counters, x, y, video_on, hsync and vsync hold.
- frame_tick:
  - Asserted for exactly one clk_100MHz cycle on the enable edge whose registered output is (x=0, y=V_ACTIVE).
  - Cleared on the next clock regardless of pix_en.
  - pix_en held continuously high is legal; frame_tick is still one cycle per frame.
- Reset mid-frame clears everything immediately without a clock edge. Timing restarts at (0,0) on the first enable after release.
- Counter widths: 10 bits. No arithmetic overflow occurs, since every compare limit is < 1024.

Optional Feature:
- Macro: VGA_GAME_TICK_EN.
- Defined:
  - A frame counter 0..GAME_DIV-1 increments on each frame_tick.
  - game_tick pulses in the same cycle as the frame_tick that wraps the counter (1 clock wide).
  - For GAME_DIV=12 this gives 5 Hz.
- Undefined:
  - The frame counter is not instantiated.
  - game_tick is tied to 0; the port still exists.

Decomposition:
- Package vga_pkg holds:
  - the default timing constants, H_TOTAL and V_TOTAL
  - coord_t (logic [9:0])
  - the hsync/vsync window bounds
- Sub-module wrap_counter (parameter MAX, inputs en and clr, outputs count and wrap) is natural. It is instantiated for h_cnt, v_cnt and the game-tick frame counter.

Test Plan:
- Reset, then pix_en held 1 -> after 1st enable x=0, y=0, video_on=1, hsync=1. After 641st enable x=640, video_on=0.
- Continuous enables over one line -> hsync low for exactly 96 consecutive enables, first at x=656, last at x=751. Next line starts at x=0, y=1.
- 420000 continuous enables -> exactly one frame_tick, aligned with x=0, y=480. vsync low for exactly 1600 enables (y=490..491). Counters return to x=0, y=0.
- pix_en 1-of-4 pattern -> outputs change only on enable cycles. frame_tick is exactly 1 clock wide, and there are 4*420000 clocks between consecutive frame_ticks.
- reset asserted asynchronously at x=300, y=100 -> outputs take reset values before the next clock edge. After release, the first enable gives x=0, y=0.
- VGA_GAME_TICK_EN with GAME_DIV=3, 7 frames -> game_tick coincides with the 3rd and 6th frame_tick only. Without the macro -> game_tick stays 0.
